// File: rtl/lfsr_checker.sv
// PRBS self-check for the 26-bit x^26+x^6+x^2+x+1 Fibonacci LFSR: hunt, sync, lock, count errors.
// Define LFSR_CHK_RESEED_EN to re-seed the prediction from the received sample on a LOCK mismatch.
module lfsr_checker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [26:1]      din,
   input  logic             din_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCK = 2'd2} state_t;

   localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
   localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

   function automatic logic [26:1] nxt(input logic [26:1] c);
      return {c[25:1], c[26] ^ c[6] ^ c[2] ^ c[1]};
   endfunction

   state_t           state_q, state_d;
   logic [26:1]      pred_q, pred_d;
   logic [3:0]       run_q, run_d;
   logic             err_q, err_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit, cnt_inc;

   assign hit = (din == pred_q);

   always_comb begin
      state_d = state_q;
      pred_d  = pred_q;
      run_d   = run_q;
      err_d   = 1'b0;
      cnt_inc = 1'b0;
      if (din_valid) begin
         case (state_q)
            HUNT: if (din != '0) begin
               pred_d  = nxt(din);
               run_d   = '0;
               state_d = SYNC;
            end
            SYNC: if (hit) begin
               pred_d = nxt(din);
               if (run_q == LOCK_LAST) begin
                  state_d = LOCK;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 4'd1;
               end
            end else begin
               state_d = HUNT;
               run_d   = '0;
            end
            LOCK: if (hit) begin
               run_d  = '0;
               pred_d = nxt(pred_q);
            end else begin
               err_d   = 1'b1;
               cnt_inc = 1'b1;
`ifdef LFSR_CHK_RESEED_EN
               pred_d  = nxt(din);
`else
               pred_d  = nxt(pred_q);
`endif
               if (run_q == UNLOCK_LAST) begin
                  state_d = HUNT;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 4'd1;
               end
            end
            default: begin
               state_d = HUNT;
               run_d   = '0;
            end
         endcase
      end
      locked_d = (state_d == LOCK);
   end

   // A clear coinciding with a counted error leaves that error in the count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt)
         cnt_d = cnt_inc ? CNT_W'(1) : '0;
      else if (cnt_inc && cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         pred_q   <= '0;
         run_q    <= '0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pred_q   <= pred_d;
         run_q    <= run_d;
         err_q    <= err_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

   assign locked  = locked_q;
   assign err     = err_q;
   assign err_cnt = cnt_q;
   assign state   = state_q;

endmodule
